// File: rtl/reel_pkg.sv
// rtl/reel_pkg.sv - shared widths, step encoding and quadrature decode helper
package reel_pkg;

   localparam int RATE_W = 9;
   localparam int ACC_W  = 12;
   localparam logic [RATE_W-1:0] RATE_MAX = 9'd511;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_FWD,
      STEP_REV,
      STEP_ILLEGAL
   } step_t;

   // Position of an {a,b} level on the forward cycle 00 -> 01 -> 11 -> 10.
   function automatic logic [1:0] quad_pos(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   // Distance travelled between two levels: 1 forward, 3 reverse, 2 is a double change.
   function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] d;
      d = quad_pos(cur) - quad_pos(prev);
      case (d)
         2'd0:    return STEP_NONE;
         2'd1:    return STEP_FWD;
         2'd3:    return STEP_REV;
         default: return STEP_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/enc_debounce.sv
// rtl/enc_debounce.sv - two-flop synchroniser plus stability filter for one encoder pin
module enc_debounce #(
   parameter int FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level
);

   localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Bring the pin into the clock domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed for FILTER_CYCLES cycles in a row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (sync2 != level) begin
         if (cnt == CW'(FILTER_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/reel_rate_meter.sv
// rtl/reel_rate_meter.sv - quadrature encoder to windowed, smoothed reel-in rate
module reel_rate_meter
   import reel_pkg::*;
#(
   parameter int WINDOW_CYCLES = 2500000,
   parameter int FILTER_CYCLES = 4,
   parameter int SCALE_SHIFT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enc_a,
   input  logic              enc_b,
   output logic [RATE_W-1:0] reel,
   output logic              sample_valid,
   output logic              dir,
   output logic              enc_err
);

   localparam int WCW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   // Wide enough that any 12-bit count shifted by up to 11 cannot overflow.
   localparam int SHW = ACC_W + 11;

   logic                    fa;
   logic                    fb;
   logic [1:0]              cur;
   logic [1:0]              prev;
   logic                    prev_valid;
   step_t                   step;
   logic signed [ACC_W-1:0] step_val;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W:0]   acc_sum;
   logic signed [ACC_W-1:0] acc_sat;
   logic [WCW-1:0]          win_cnt;
   logic                    tc;
   logic [SHW-1:0]          scaled;
   logic [RATE_W-1:0]       rate;
   logic [RATE_W:0]         smooth_sum;
   logic [RATE_W-1:0]       reel_next;

   enc_debounce #(.FILTER_CYCLES(FILTER_CYCLES)) u_deb_a (
      .clk   (clk),
      .rst   (rst),
      .pin   (enc_a),
      .level (fa)
   );

   enc_debounce #(.FILTER_CYCLES(FILTER_CYCLES)) u_deb_b (
      .clk   (clk),
      .rst   (rst),
      .pin   (enc_b),
      .level (fb)
   );

   assign cur = {fa, fb};
   assign tc  = (win_cnt == WCW'(WINDOW_CYCLES - 1));

   // Track the previous filtered level; the first change after reset only arms decoding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev       <= 2'b00;
         prev_valid <= 1'b0;
      end else begin
         prev       <= cur;
         prev_valid <= prev_valid | (cur != prev);
      end
   end

   // Decode this cycle's step and the saturating accumulator update.
   always_comb begin
      step     = STEP_NONE;
      step_val = '0;
      if (prev_valid) begin
         step = decode_step(prev, cur);
      end
      case (step)
         STEP_FWD: step_val = ACC_W'(1);
         STEP_REV: step_val = '1;
         default:  step_val = '0;
      endcase
      acc_sum = {acc[ACC_W-1], acc} + {step_val[ACC_W-1], step_val};
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
         acc_sat = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         acc_sat = acc_sum[ACC_W-1:0];
      end
   end

   // Window rate from the accumulated count, then average it into the previous output.
   always_comb begin
      rate   = '0;
      scaled = SHW'($unsigned(acc)) << SCALE_SHIFT;
      if (!acc[ACC_W-1] && (acc != '0)) begin
         rate = (scaled > SHW'(RATE_MAX)) ? RATE_MAX : scaled[RATE_W-1:0];
      end
      smooth_sum = {1'b0, reel} + {1'b0, rate};
      reel_next  = RATE_W'(smooth_sum >> 1);
   end

   // Window counter, accumulator, and the output registers that change only at window ends.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_cnt      <= '0;
         acc          <= '0;
         reel         <= '0;
         sample_valid <= 1'b0;
         dir          <= 1'b0;
         enc_err      <= 1'b0;
      end else begin
         win_cnt      <= tc ? '0 : win_cnt + 1'b1;
         sample_valid <= tc;
         if (tc) begin
            reel <= reel_next;
            acc  <= step_val;
         end else begin
            acc <= acc_sat;
         end
         if (step == STEP_FWD) begin
            dir <= 1'b1;
         end else if (step == STEP_REV) begin
            dir <= 1'b0;
         end
         if (step == STEP_ILLEGAL) begin
            enc_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reel_rate_meter.sv
// tb/tb_reel_rate_meter.sv - scoreboard bench for reel_rate_meter
module tb_reel_rate_meter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       a1 = 1'b0, b1 = 1'b0, a2 = 1'b0, b2 = 1'b0;
   logic [8:0] reel1, reel2;
   logic       sv1, sv2, dir1, dir2, err1, err2;

   int cyc;
   int idx1 = 0;
   int idx2 = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int reel;
      int dir;
      int err;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   reel_rate_meter #(.WINDOW_CYCLES(100), .FILTER_CYCLES(4), .SCALE_SHIFT(2)) dut1 (
      .clk(clk), .rst(rst), .enc_a(a1), .enc_b(b1),
      .reel(reel1), .sample_valid(sv1), .dir(dir1), .enc_err(err1)
   );

   reel_rate_meter #(.WINDOW_CYCLES(100), .FILTER_CYCLES(4), .SCALE_SHIFT(5)) dut2 (
      .clk(clk), .rst(rst), .enc_a(a2), .enc_b(b2),
      .reel(reel2), .sample_valid(sv2), .dir(dir2), .enc_err(err2)
   );

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   function automatic logic [1:0] gray(input int i);
      logic [1:0] v;
      v = i[1:0];
      return {v[1], v[1] ^ v[0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic at_cycle(input int p);
      while (cyc != p - 1) @(negedge clk);
   endtask

   task automatic move1(input int d);
      idx1 = (idx1 + d) & 3;
      {a1, b1} = gray(idx1);
   endtask

   task automatic move2(input int d);
      idx2 = (idx2 + d) & 3;
      {a2, b2} = gray(idx2);
   endtask

   task automatic push1(input int r, input int d, input int e);
      exp_t x;
      x.reel = r; x.dir = d; x.err = e;
      q1.push_back(x);
   endtask

   task automatic push2(input int r, input int d, input int e);
      exp_t x;
      x.reel = r; x.dir = d; x.err = e;
      q2.push_back(x);
   endtask

   // Scoreboard monitor for the SCALE_SHIFT=2 instance.
   initial begin
      int w = 0;
      forever begin
         @(negedge clk);
         if (sv1) begin
            if (q1.size() == 0) begin
               check($sformatf("dut1 unexpected sample %0d", w), 1, 0);
            end else begin
               exp_t x;
               x = q1.pop_front();
               check($sformatf("dut1 win%0d reel", w), reel1, x.reel);
               check($sformatf("dut1 win%0d dir", w), dir1, x.dir);
               check($sformatf("dut1 win%0d enc_err", w), err1, x.err);
            end
            w++;
         end
      end
   end

   // Scoreboard monitor for the SCALE_SHIFT=5 instance.
   initial begin
      int w = 0;
      forever begin
         @(negedge clk);
         if (sv2) begin
            if (q2.size() == 0) begin
               check($sformatf("dut2 unexpected sample %0d", w), 1, 0);
            end else begin
               exp_t x;
               x = q2.pop_front();
               check($sformatf("dut2 win%0d reel", w), reel2, x.reel);
               check($sformatf("dut2 win%0d dir", w), dir2, x.dir);
               check($sformatf("dut2 win%0d enc_err", w), err2, x.err);
            end
            w++;
         end
      end
   end

   initial begin
      #60000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      fork
         begin
            // windows 0..11: priming, fwd x10, rev x8, decay, glitch, illegal, boundary
            push1(0, 0, 0);  push1(20, 1, 0); push1(10, 0, 0); push1(5, 0, 0);
            push1(2, 0, 0);  push1(1, 0, 0);  push1(0, 0, 0);  push1(2, 1, 0);
            push1(3, 1, 1);  push1(1, 1, 1);  push1(0, 1, 1);  push1(2, 1, 1);
            at_cycle(1); move1(1);
            for (int i = 0; i < 10; i++) begin at_cycle(95 + 10 * i); move1(1); end
            for (int i = 0; i < 8; i++) begin at_cycle(195 + 10 * i); move1(-1); end
            at_cycle(705); move1(1);
            at_cycle(730); b1 = ~b1;
            at_cycle(733); b1 = ~b1;
            at_cycle(805); move1(2);
            at_cycle(830); move1(1);
            at_cycle(1094); move1(1);
            for (int i = 0; i < 6; i++) begin at_cycle(1195 + 8 * i); move1(1); end
         end
         begin
            push2(0, 0, 0);   push2(255, 1, 0); push2(383, 1, 0); push2(447, 1, 0);
            push2(223, 1, 0); push2(111, 1, 0); push2(55, 1, 0);  push2(27, 1, 0);
            push2(13, 1, 0);  push2(6, 1, 0);   push2(3, 1, 0);   push2(1, 1, 0);
            at_cycle(1); move2(1);
            for (int i = 0; i < 60; i++) begin at_cycle(95 + 5 * i); move2(1); end
         end
      join

      at_cycle(1251);
      check("queue1 drained before reset", q1.size(), 0);
      check("queue2 drained before reset", q2.size(), 0);
      rst = 1'b0;
      #1;
      check("reset reel1", reel1, 0);
      check("reset dir1", dir1, 0);
      check("reset enc_err1", err1, 0);
      check("reset sample_valid1", sv1, 0);
      check("reset reel2", reel2, 0);
      check("reset dir2", dir2, 0);
      @(negedge clk);
      @(negedge clk);
      push1(0, 0, 0); push1(2, 1, 0);
      push2(0, 0, 0); push2(0, 0, 0);
      rst = 1'b1;
      at_cycle(100);
      check("post-reset sample_valid at 99", sv1, 0);
      at_cycle(101);
      check("post-reset sample_valid at 100", sv1, 1);
      at_cycle(105); move1(1);
      at_cycle(211);
      check("queue1 drained at end", q1.size(), 0);
      check("queue2 drained at end", q2.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
